// File: rtl/booth_div_32.sv
// Purpose : sequential signed 32-bit non-restoring divider, Z = {remainder, quotient}.
// Latency : 33 cycles from accepting edge to done (1 cycle for a zero divisor).
// Backpr. : no queuing; start is sampled only when idle and ignored while busy.
//
// Ports:
//   clock        rising-edge clock
//   clear_n      asynchronous active-low reset, aborts any division in flight
//   start        request strobe, sampled only in IDLE
//   Q_input      signed dividend, captured at accept
//   M_input      signed divisor, captured at accept
//   Z            {remainder, quotient}, registered and held until the next result
//   busy         high while a division is in progress
//   done         one-cycle pulse when Z is written
//   div_by_zero  set with done when the divisor was zero, held until next accept
module booth_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Q_input,
  input  logic [WIDTH-1:0]     M_input,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DZ   = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH:0]       a_q;        // signed partial remainder, one guard bit
  logic [WIDTH-1:0]     q_q;        // quotient bits shift in here
  logic [WIDTH:0]       m_q;        // divisor magnitude, zero-extended
  logic                 neg_quot_q;
  logic                 neg_rem_q;
  logic [2*WIDTH-1:0]   z_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dz_q;

  // Operand magnitudes; 0x8000_0000 maps to itself, which is correct unsigned.
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     m_mag;

  // One non-restoring step and the final sign fix-up.
  logic [WIDTH:0]       a_shift;
  logic [WIDTH:0]       a_step_d;
  logic [WIDTH-1:0]     q_step_d;
  logic [WIDTH-1:0]     rem_mag;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quot_d;

  always_comb begin
    q_mag    = Q_input[WIDTH-1] ? -Q_input : Q_input;
    m_mag    = M_input[WIDTH-1] ? -M_input : M_input;

    a_shift  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    // Sign of the previous partial remainder picks subtract or add.
    a_step_d = a_q[WIDTH] ? (a_shift + m_q) : (a_shift - m_q);
    q_step_d = {q_q[WIDTH-2:0], ~a_step_d[WIDTH]};

    // A negative final remainder is restored by one more add of M.
    rem_mag  = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : a_q[WIDTH-1:0];
    // Truncating division: remainder follows the dividend's sign.
    rem_d    = neg_rem_q ? -rem_mag : rem_mag;
    quot_d   = neg_quot_q ? -q_q : q_q;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      z_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_quot_q <= Q_input[WIDTH-1] ^ M_input[WIDTH-1];
            neg_rem_q  <= Q_input[WIDTH-1];
            a_q        <= '0;
            m_q        <= {1'b0, m_mag};
            cnt_q      <= '0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b1;
            if (M_input == '0) begin
              // Raw dividend is kept so it can be returned unchanged in HI.
              q_q     <= Q_input;
              state_q <= DZ;
            end else begin
              q_q     <= q_mag;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          a_q   <= a_step_d;
          q_q   <= q_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          z_q     <= {rem_d, quot_d};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DZ: begin
          z_q     <= {q_q, {WIDTH{1'b1}}};
          dz_q    <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Z           = z_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_booth_div_32.sv
// Purpose : self-checking bench for booth_div_32 against a transaction-level reference.
// Latency : expects done 33 cycles after accept, 1 cycle for a zero divisor.
// Backpr. : start while busy must be ignored; start in the done cycle is accepted.
module tb_booth_div_32;

  logic        clock   = 1'b0;
  logic        clear_n = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] Q_input = '0;
  logic [31:0] M_input = '0;
  logic [63:0] Z;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  booth_div_32 #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .Q_input     (Q_input),
    .M_input     (M_input),
    .Z           (Z),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference result from plain 64-bit signed arithmetic (no INT_MIN/-1 overflow).
  function automatic logic [63:0] ref_z(input logic [31:0] a, input logic [31:0] b);
    int     sa;
    int     sb;
    longint la;
    longint lb;
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: results appear a fixed latency after acceptance.
  logic [63:0] m_z      = '0;
  logic [63:0] m_res    = '0;
  logic        m_res_dz = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_dz     = 1'b0;
  int          m_cnt    = 0;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_z    <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_z    <= m_res;
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_dz   <= m_res_dz;
        end
      end else if (start) begin
        m_res    <= ref_z(Q_input, M_input);
        m_res_dz <= (M_input == 32'd0);
        m_dz     <= 1'b0;
        m_busy   <= 1'b1;
        m_cnt    <= (M_input == 32'd0) ? 1 : 33;
      end
    end
  end

  // Every cycle: all outputs against the model, sampled away from the active edge.
  always @(negedge clock) begin
    check64("model_z", Z, m_z);
    check_int("model_busy", int'(busy), int'(m_busy));
    check_int("model_done", int'(done), int'(m_done));
    check_int("model_dz", int'(div_by_zero), int'(m_dz));
  end

  // Issue one division starting at the current negedge, scramble inputs while
  // busy, and return at the negedge where done is high.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expz, input logic expdz, input string name);
    int lat;
    int bcnt;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    start   = 1'b1;
    Q_input = a;
    M_input = b;
    @(negedge clock);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      Q_input = $urandom;
      M_input = $urandom;
      @(negedge clock);
      lat++;
    end
    check_int({name, "_done_seen"}, int'(done), 1);
    check_int({name, "_latency"}, lat, exp_lat);
    check_int({name, "_busy_cycles"}, bcnt, exp_lat);
    check64({name, "_z"}, Z, expz);
    check_int({name, "_dz"}, int'(div_by_zero), int'(expdz));
  endtask

  initial begin
    int          n;
    int          seen;
    logic [31:0] a;
    logic [31:0] b;

    clear_n = 1'b0;
    repeat (3) @(negedge clock);
    check64("reset_z", Z, 64'd0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_dz", int'(div_by_zero), 0);
    clear_n = 1'b1;
    @(negedge clock);

    do_div(32'd7,          32'd2,          {32'h0000_0001, 32'h0000_0003}, 1'b0, "p7_p2");
    do_div(32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "m7_p2");
    do_div(32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, "p7_m2");
    do_div(32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h0000_0003}, 1'b0, "m7_m2");
    @(negedge clock);
    do_div(32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 1'b0, "min_m1");
    do_div(32'd0,          32'hFFFF_FFFD,  64'd0,                          1'b0, "zero_m3");
    @(negedge clock);
    do_div(32'd12345,      32'd0,          {32'h0000_3039, 32'hFFFF_FFFF}, 1'b1, "dz");
    do_div(32'd9,          32'd3,          {32'h0000_0000, 32'h0000_0003}, 1'b0, "after_dz");

    // start while busy must be ignored
    @(negedge clock);
    start   = 1'b1;
    Q_input = 32'd100;
    M_input = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start   = 1'b1;
    Q_input = 32'd50;
    M_input = 32'd5;
    @(negedge clock);
    start   = 1'b0;
    Q_input = 32'd1;
    M_input = 32'd1;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_int("busy_ignore_done_seen", int'(done), 1);
    check64("busy_ignore_z", Z, {32'd2, 32'd14});
    // start in the done cycle is accepted
    do_div(32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, "b2b");

    // reset in the middle of a division
    @(negedge clock);
    start   = 1'b1;
    Q_input = 32'd1000;
    M_input = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    check64("abort_z", Z, 64'd0);
    check_int("abort_busy", int'(busy), 0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    check_int("abort_no_done", seen, 0);
    do_div(32'd21, 32'd4, {32'd1, 32'd5}, 1'b0, "after_abort");

    // signed pairs against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = $urandom_range(1, 20);
      if (i % 5 == 0) b = -b;
      if (i % 7 == 0) a = $urandom_range(0, 100);
      if (i % 11 == 0) a = -a;
      if (b == 32'd0) b = 32'd1;
      do_div(a, b, ref_z(a, b), 1'b0, "rand");
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
